// File: rtl/tc_serial_decoder.sv
// tc_serial_decoder
//   Receive end of the bit-serial two's-complement link. Takes a framed,
//   LSB-first stream that the upstream negator has already negated, negates
//   it again bit by bit (pass bits up to and including the first 1, invert
//   the rest), deserializes it and presents the recovered word in parallel.
//
//   Build option: define TC_PARITY_EN to append an even-parity bit
//   (computed over the received, pre-negation data bits) to every frame.
//
// Ports
//   t_clk  in   clock, all state updates on the rising edge
//   r      in   synchronous active-high reset
//   i      in   serial data, LSB first
//   i_vld  in   i carries a valid bit this cycle (0 = stall, state held)
//   i_sof  in   start of frame, qualified by i_vld, marks bit 0
//   y      out  recovered word, held between frames
//   y_vld  out  one-cycle strobe, y just updated
//   ovf    out  with y_vld: received word was -2^(WIDTH-1)
//   err    out  one-cycle pulse: frame aborted by i_sof (or parity mismatch)
//   busy   out  frame in progress
module tc_serial_decoder #(
    parameter int WIDTH = 8
) (
    input  logic             t_clk,
    input  logic             r,
    input  logic             i,
    input  logic             i_vld,
    input  logic             i_sof,
    output logic [WIDTH-1:0] y,
    output logic             y_vld,
    output logic             ovf,
    output logic             err,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    LAST_BIT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef TC_PARITY_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} state_t;
`else
    typedef enum logic [0:0] {S_IDLE, S_SHIFT} state_t;
`endif

    state_t           r_state, w_state;
    logic [CW-1:0]    r_cnt,   w_cnt;
    logic             r_seen,  w_seen;
    logic [WIDTH-1:0] r_sr,    w_sr;
    logic [WIDTH-1:0] r_y,     w_y;
    logic             r_yvld,  w_yvld;
    logic             r_ovf,   w_ovf;
    logic             r_err,   w_err;
    logic             w_d;
`ifdef TC_PARITY_EN
    logic             r_par,   w_par;
`endif

    always_ff @(posedge t_clk) begin
        if (r) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_seen  <= 1'b0;
            r_sr    <= '0;
            r_y     <= '0;
            r_yvld  <= 1'b0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
`ifdef TC_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_seen  <= w_seen;
            r_sr    <= w_sr;
            r_y     <= w_y;
            r_yvld  <= w_yvld;
            r_ovf   <= w_ovf;
            r_err   <= w_err;
`ifdef TC_PARITY_EN
            r_par   <= w_par;
`endif
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_seen  = r_seen;
        w_sr    = r_sr;
        w_y     = r_y;
        w_yvld  = 1'b0;
        w_ovf   = 1'b0;
        w_err   = 1'b0;
`ifdef TC_PARITY_EN
        w_par   = r_par;
`endif
        // Mealy negation: invert only once a 1 has already gone past.
        w_d = r_seen ? ~i : i;

        if (i_vld) begin
            if (i_sof) begin
                // Any start-of-frame outside IDLE aborts the current frame;
                // the sof bit always becomes bit 0 of a fresh frame.
                w_err   = (r_state != S_IDLE);
                w_state = S_SHIFT;
                w_cnt   = CW'(1);
                w_seen  = i;
                w_sr    = {i, r_sr[WIDTH-1:1]};
`ifdef TC_PARITY_EN
                w_par   = i;
`endif
            end else begin
                case (r_state)
                    S_SHIFT: begin
                        w_sr   = {w_d, r_sr[WIDTH-1:1]};
                        w_seen = r_seen | i;
`ifdef TC_PARITY_EN
                        w_par  = r_par ^ i;
`endif
                        if (r_cnt == LAST_BIT) begin
                            w_cnt   = '0;
`ifdef TC_PARITY_EN
                            w_state = S_PARITY;
`else
                            w_state = S_IDLE;
                            w_y     = w_sr;
                            w_yvld  = 1'b1;
                            w_ovf   = (w_sr == MIN_NEG);
`endif
                        end else begin
                            w_cnt = r_cnt + CW'(1);
                        end
                    end
`ifdef TC_PARITY_EN
                    S_PARITY: begin
                        w_state = S_IDLE;
                        w_y     = r_sr;
                        w_yvld  = 1'b1;
                        w_ovf   = (r_sr == MIN_NEG);
                        w_err   = i ^ r_par;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign y     = r_y;
    assign y_vld = r_yvld;
    assign ovf   = r_ovf;
    assign err   = r_err;
    assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_tc_serial_decoder.sv
// tb_tc_serial_decoder
//   Self-checking bench for tc_serial_decoder (WIDTH=8). A frame-level model
//   collects the raw received bits and, at frame end, predicts y as the
//   arithmetic negation of the raw word. A compare process checks every
//   output on every falling edge; directed frames also pin literal values.
//   Honours TC_PARITY_EN the same way as the design.
module tb_tc_serial_decoder;

    localparam int W = 8;
`ifdef TC_PARITY_EN
    localparam int FLEN = W + 1;
`else
    localparam int FLEN = W;
`endif
    localparam logic [W-1:0] MINV = 8'h80;

    logic         t_clk = 1'b0;
    logic         r     = 1'b1;
    logic         i     = 1'b0;
    logic         i_vld = 1'b0;
    logic         i_sof = 1'b0;
    logic [W-1:0] y;
    logic         y_vld;
    logic         ovf;
    logic         err;
    logic         busy;

    tc_serial_decoder #(.WIDTH(W)) dut (
        .t_clk (t_clk),
        .r     (r),
        .i     (i),
        .i_vld (i_vld),
        .i_sof (i_sof),
        .y     (y),
        .y_vld (y_vld),
        .ovf   (ovf),
        .err   (err),
        .busy  (busy)
    );

    always #5 t_clk = ~t_clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    // Model state
    logic         in_frame = 1'b0;
    int           pos      = 0;
    logic [W-1:0] raw      = '0;
    logic [W-1:0] exp_y    = '0;
    logic         exp_vld  = 1'b0;
    logic         exp_ovf  = 1'b0;
    logic         exp_err  = 1'b0;
    logic         exp_busy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, return at negedge.
    task automatic step(input logic rr, input logic v, input logic s, input logic b);
        r = rr; i_vld = v; i_sof = s; i = b;
        @(posedge t_clk);
        exp_vld = 1'b0; exp_ovf = 1'b0; exp_err = 1'b0;
        if (rr) begin
            in_frame = 1'b0; pos = 0; exp_y = '0;
        end else if (v) begin
            if (s) begin
                exp_err  = in_frame;
                in_frame = 1'b1;
                raw      = '0;
                raw[0]   = b;
                pos      = 1;
            end else if (in_frame) begin
                if (pos < W) raw[pos] = b;
                else         exp_err  = (b != ^raw);
                pos++;
                if (pos == FLEN) begin
                    exp_y    = -raw;
                    exp_vld  = 1'b1;
                    exp_ovf  = (raw == MINV);
                    in_frame = 1'b0;
                end
            end
        end
        exp_busy = in_frame;
        chk_en   = 1'b1;
        @(negedge t_clk);
    endtask

    task automatic send_data(input logic [W-1:0] word, input int stall_after, input int nstall);
        for (int b = 0; b < W; b++) begin
            step(1'b0, 1'b1, (b == 0), word[b]);
            if (b == stall_after)
                for (int k = 0; k < nstall; k++) step(1'b0, 1'b0, 1'b0, 1'($urandom));
        end
    endtask

    task automatic send_frame(input logic [W-1:0] word, input int stall_after, input int nstall);
        send_data(word, stall_after, nstall);
`ifdef TC_PARITY_EN
        step(1'b0, 1'b1, 1'b0, ^word);
`endif
    endtask

    always @(negedge t_clk) begin
        if (chk_en) begin
            chk("y",     32'(y),     32'(exp_y));
            chk("y_vld", 32'(y_vld), 32'(exp_vld));
            chk("ovf",   32'(ovf),   32'(exp_ovf));
            chk("err",   32'(err),   32'(exp_err));
            chk("busy",  32'(busy),  32'(exp_busy));
        end
    end

    initial begin
        logic [W-1:0] w0f;
        logic [W-1:0] w01;
        w0f = 8'h0F;
        w01 = 8'h01;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_y",    32'(y),     32'h0);
        chk("rst_vld",  32'(y_vld), 32'h0);
        chk("rst_busy", 32'(busy),  32'h0);

        // 1: 0x03 -> 0xFD
        send_frame(8'h03, -1, 0);
        chk("t1_y",   32'(y),     32'hFD);
        chk("t1_vld", 32'(y_vld), 32'h1);
        chk("t1_ovf", 32'(ovf),   32'h0);
        chk("t1_err", 32'(err),   32'h0);
        chk("t1_mdl", 32'(exp_y), 32'hFD);

        // 2: back-to-back 0x00 then 0x7F
        send_frame(8'h00, -1, 0);
        chk("t2a_y",   32'(y),     32'h00);
        chk("t2a_vld", 32'(y_vld), 32'h1);
        send_frame(8'h7F, -1, 0);
        chk("t2b_y",   32'(y),     32'h81);
        chk("t2b_vld", 32'(y_vld), 32'h1);
        chk("t2_mdl",  32'(exp_y), 32'h81);

        // 3: most negative value overflows
        send_frame(8'h80, -1, 0);
        chk("t3_y",   32'(y),     32'h80);
        chk("t3_ovf", 32'(ovf),   32'h1);
        chk("t3_vld", 32'(y_vld), 32'h1);

        // 4: three stall cycles between bits 2 and 3
        step(1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h05, 2, 3);
        chk("t4_y",   32'(y),     32'hFB);
        chk("t4_vld", 32'(y_vld), 32'h1);

        // 5: abort 0x0F at bit 4, then 0x01
        for (int b = 0; b < 4; b++) step(1'b0, 1'b1, (b == 0), w0f[b]);
        step(1'b0, 1'b1, 1'b1, w01[0]);
        chk("t5_err",  32'(err),   32'h1);
        chk("t5_mdle", 32'(exp_err), 32'h1);
        for (int b = 1; b < W; b++) step(1'b0, 1'b1, 1'b0, w01[b]);
`ifdef TC_PARITY_EN
        step(1'b0, 1'b1, 1'b0, ^w01);
`endif
        chk("t5_y",   32'(y),     32'hFF);
        chk("t5_vld", 32'(y_vld), 32'h1);
        chk("t5_err2", 32'(err),  32'h0);

        // 6: reset at bit 5, then 0x02
        for (int b = 0; b < 5; b++) step(1'b0, 1'b1, (b == 0), w0f[b]);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("t6_rst_y",    32'(y),     32'h00);
        chk("t6_rst_vld",  32'(y_vld), 32'h0);
        chk("t6_rst_busy", 32'(busy),  32'h0);
        send_frame(8'h02, -1, 0);
        chk("t6_y",   32'(y),     32'hFE);
        chk("t6_vld", 32'(y_vld), 32'h1);

`ifdef TC_PARITY_EN
        // Parity mismatch: 0x03 has even parity 0, send 1
        send_data(8'h03, -1, 0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("tp_y",   32'(y),     32'hFD);
        chk("tp_vld", 32'(y_vld), 32'h1);
        chk("tp_err", 32'(err),   32'h1);
`endif

        // Random traffic: stalls, junk bits in idle, aborts, occasional reset
        for (int c = 0; c < 4000; c++) begin
            logic rr, v, s;
            rr = ($urandom_range(0, 199) == 0);
            v  = ($urandom_range(0, 3) != 0);
            if (in_frame) s = ($urandom_range(0, 39) == 0);
            else          s = ($urandom_range(0, 2) != 0);
            step(rr, v, s, 1'($urandom));
        end

        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
